// File: rtl/pwm_duty_ctrl.sv
// rtl/pwm_duty_ctrl.sv - duty-select synchroniser/debouncer committing codes at PWM period wrap
// Build option PWM_DUTY_IMMEDIATE_EN: commit on debounce completion, ignoring period_wrap.
module pwm_duty_ctrl #(
    parameter int DB_CYCLES = 255,
    parameter int DBW       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_raw,
    input  logic       period_wrap,
    output logic [3:0] sw_out,
    output logic       duty_changed,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PENDING = 2'd2
    } state_t;

    localparam logic [DBW-1:0] CNT_LAST = DBW'(DB_CYCLES - 1);

    state_t         state_q, state_d;
    logic [3:0]     s1_q, s2_q;
    logic [3:0]     cand_q, cand_d;
    logic [DBW-1:0] cnt_q, cnt_d;
    logic [3:0]     sw_out_q, sw_out_d;
    logic           dc_q, dc_d;

`ifdef PWM_DUTY_IMMEDIATE_EN
    logic unused_period_wrap;
    assign unused_period_wrap = period_wrap;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s1_q     <= 4'd0;
            s2_q     <= 4'd0;
            cand_q   <= 4'd0;
            cnt_q    <= '0;
            sw_out_q <= 4'd0;
            dc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= sw_raw;
            s2_q     <= s1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            sw_out_q <= sw_out_d;
            dc_q     <= dc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        sw_out_d = sw_out_q;
        dc_d     = 1'b0;
        // A changed synchronised input always restarts debouncing, even over a wrap.
        if (s2_q != cand_q) begin
            cand_d  = s2_q;
            cnt_d   = '0;
            state_d = SETTLE;
        end else begin
            case (state_q)
                IDLE: cnt_d = '0;
                SETTLE: begin
                    if (cnt_q < CNT_LAST) begin
                        cnt_d = cnt_q + DBW'(1);
                    end else begin
                        cnt_d = '0;
                        if (cand_q == sw_out_q) begin
                            state_d = IDLE;
                        end else begin
`ifdef PWM_DUTY_IMMEDIATE_EN
                            sw_out_d = cand_q;
                            dc_d     = 1'b1;
                            state_d  = IDLE;
`else
                            state_d  = PENDING;
`endif
                        end
                    end
                end
                PENDING: begin
`ifdef PWM_DUTY_IMMEDIATE_EN
                    state_d = IDLE;
`else
                    if (period_wrap) begin
                        sw_out_d = cand_q;
                        dc_d     = 1'b1;
                        state_d  = IDLE;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign sw_out       = sw_out_q;
    assign duty_changed = dc_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb/tb_pwm_duty_ctrl.sv - randomized and directed bench for pwm_duty_ctrl against a stable-age model
module tb_pwm_duty_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw_raw = 4'd0;
    logic       period_wrap = 1'b0;
    logic [3:0] sw_out;
    logic       duty_changed;
    logic       busy;

    int vectors = 0;
    int errors  = 0;

    // Reference: synchroniser delay line, candidate, and an unbounded count of stable edges.
    logic [3:0] m_s1, m_s2, m_cand, m_out;
    int         m_age;
    bit         m_busy, m_dc;

    pwm_duty_ctrl #(.DB_CYCLES(DB), .DBW(3)) dut (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .period_wrap(period_wrap),
        .sw_out(sw_out), .duty_changed(duty_changed), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_cand = 0; m_out = 0; m_age = 0; m_busy = 0; m_dc = 0;
    endtask

    task automatic model_edge(input logic [3:0] raw, input logic w);
        m_dc = 0;
        if (m_s2 != m_cand) begin
            m_cand = m_s2; m_age = 0; m_busy = 1;
        end else if (m_busy) begin
            m_age++;
`ifdef PWM_DUTY_IMMEDIATE_EN
            if (m_age == DB) begin
                if (m_cand != m_out) begin m_out = m_cand; m_dc = 1; end
                m_busy = 0;
            end
`else
            if (m_age == DB && m_cand == m_out) m_busy = 0;
            else if (m_age > DB && w) begin m_out = m_cand; m_dc = 1; m_busy = 0; end
`endif
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic step(input logic [3:0] raw, input logic w);
        sw_raw = raw;
        period_wrap = w;
        @(posedge clk);
        model_edge(raw, w);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step(4'hF, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (sw_out !== 4'h0 || busy !== 1'b0 || duty_changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: sw_out=%h busy=%b dc=%b, required 0/0/0", sw_out, busy, duty_changed);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(4'h0, 1'b0);
            vectors++;
            if (busy !== 1'b0 || sw_out !== 4'h0) begin
                errors++;
                $display("FAIL reset_release: busy=%b sw_out=%h, required 0/0", busy, sw_out);
            end
        end
    endtask

    task automatic test_clean_change();
        int dc_seen = 0;
        do_reset();
        step(4'hA, 1'b0);
        step(4'hA, 1'b0);
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL clean_busy_early: busy=%b, required 0", busy); end
        step(4'hA, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy_rise: busy=%b, required 1", busy); end
        for (int i = 3; i < 20; i++) begin
            step(4'hA, 1'b0);
            if (duty_changed === 1'b1) dc_seen++;
        end
        step(4'hA, 1'b1);
        if (duty_changed === 1'b1) dc_seen++;
        vectors++;
        if (sw_out !== 4'hA || sw_out !== m_out) begin
            errors++; $display("FAIL clean_commit: sw_out=%h, required %h", sw_out, m_out);
        end
        for (int i = 0; i < 4; i++) begin
            step(4'hA, 1'b0);
            if (duty_changed === 1'b1) dc_seen++;
        end
        vectors++;
        if (dc_seen != 1) begin errors++; $display("FAIL clean_pulses: got %0d duty_changed pulses, required 1", dc_seen); end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            step(((i / 2) % 2 == 0) ? 4'h3 : 4'h5, 1'b0);
            vectors++;
            if (sw_out !== m_out || duty_changed !== m_dc || busy !== m_busy) begin
                errors++;
                $display("FAIL bounce_toggle: out=%h dc=%b busy=%b, required %h/%b/%b", sw_out, duty_changed, busy, m_out, m_dc, m_busy);
            end
        end
        for (int i = 0; i < 12; i++) begin
            step(4'h5, (i == 11));
            vectors++;
            if (sw_out !== m_out || duty_changed !== m_dc || busy !== m_busy) begin
                errors++;
                $display("FAIL bounce_settle: out=%h dc=%b busy=%b, required %h/%b/%b", sw_out, duty_changed, busy, m_out, m_dc, m_busy);
            end
        end
        vectors++;
        if (sw_out !== 4'h5) begin errors++; $display("FAIL bounce_final: sw_out=%h, required 5", sw_out); end
    endtask

    task automatic test_revert();
        int dc_seen = 0;
        for (int i = 0; i < 10; i++) step(4'h2, 1'b0);
        step(4'h2, 1'b1);
        for (int i = 0; i < 3; i++) step(4'h2, 1'b0);
        vectors++;
        if (sw_out !== 4'h2) begin errors++; $display("FAIL revert_setup: sw_out=%h, required 2", sw_out); end
        step(4'h7, 1'b0);
        step(4'h7, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(4'h2, (i % 3) == 0);
            if (duty_changed === 1'b1) dc_seen++;
            vectors++;
            if (sw_out !== m_out || busy !== m_busy) begin
                errors++;
                $display("FAIL revert_track: out=%h busy=%b, required %h/%b", sw_out, busy, m_out, m_busy);
            end
        end
        vectors++;
        if (dc_seen != 0 || sw_out !== 4'h2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL revert_final: pulses=%0d out=%h busy=%b, required 0/2/0", dc_seen, sw_out, busy);
        end
    endtask

    task automatic test_collision();
        for (int i = 0; i < 10; i++) step(4'h6, 1'b0);
        step(4'h9, 1'b0);
        step(4'h9, 1'b0);
        step(4'h9, 1'b1);
        vectors++;
        if (sw_out !== m_out || duty_changed !== m_dc || busy !== m_busy) begin
            errors++;
            $display("FAIL collision_model: out=%h dc=%b busy=%b, required %h/%b/%b", sw_out, duty_changed, busy, m_out, m_dc, m_busy);
        end
`ifndef PWM_DUTY_IMMEDIATE_EN
        vectors++;
        if (sw_out !== 4'h2 || duty_changed !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL collision_nocommit: out=%h dc=%b busy=%b, required 2/0/1", sw_out, duty_changed, busy);
        end
`endif
        for (int i = 0; i < 8; i++) step(4'h9, 1'b0);
        step(4'h9, 1'b1);
        step(4'h9, 1'b0);
        vectors++;
        if (sw_out !== 4'h9) begin errors++; $display("FAIL collision_later: sw_out=%h, required 9", sw_out); end
    endtask

    task automatic test_immediate();
`ifdef PWM_DUTY_IMMEDIATE_EN
        int edges = 0;
        do_reset();
        while (sw_out !== 4'hC && edges < 20) begin
            step(4'hC, 1'b0);
            edges++;
        end
        vectors++;
        if (edges != DB + 3) begin errors++; $display("FAIL immediate_latency: %0d edges, required %0d", edges, DB + 3); end
        vectors++;
        if (duty_changed !== 1'b1) begin errors++; $display("FAIL immediate_pulse: dc=%b, required 1", duty_changed); end
`endif
    endtask

    task automatic test_random();
        logic [3:0] raw = 4'h0;
        int hold = 0;
        int wrap_cnt = 0;
        int period = 5;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                raw = 4'($urandom_range(0, 15));
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 25) : $urandom_range(1, 4);
            end
            hold--;
            wrap_cnt++;
            if (wrap_cnt >= period) begin
                wrap_cnt = 0;
                period = $urandom_range(3, 12);
                step(raw, 1'b1);
            end else begin
                step(raw, 1'b0);
            end
            vectors++;
            if (sw_out !== m_out || duty_changed !== m_dc || busy !== m_busy) begin
                errors++;
                $display("FAIL random_%0d: out=%h dc=%b busy=%b, required %h/%b/%b", i, sw_out, duty_changed, busy, m_out, m_dc, m_busy);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_change();
        test_bounce();
        test_revert();
        test_collision();
        test_immediate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ctrl.md
# pwm_duty_ctrl

Conditioning stage directly upstream of the PWM generator. Synchronises and debounces the raw duty-select switches and presents a stable 4-bit duty code on `sw_out`, which drives the generator's `sw` input. A new code is committed only at a PWM period boundary, signalled by the generator's `period_wrap` pulse. This keeps the `pulse_red` duty glitch-free and preserves the generator's `pulse_red`-within-`ub_pulse` property across duty changes.

## Interface
- `DB_CYCLES`, default 255: consecutive stable cycles required before a code is accepted; legal range 2..65535.
- `DBW`, default 8: debounce counter width; must satisfy 2^DBW >= DB_CYCLES.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `sw_raw` input 4: raw, asynchronous switch levels.
- `period_wrap` input 1: one-cycle pulse from the PWM generator in the cycle its counter wraps to 0.
- `sw_out` output 4: committed duty code, feeding the generator's `sw`.
- `duty_changed` output 1: one-cycle pulse after each commit.
- `busy` output 1: high while a candidate code is settling or pending.

## Operation
- Synchroniser:
  - Two-flop synchroniser per bit: `sw_raw` → `s1` → `s2`.
  - Only `s2` is used downstream.
- Stored state: `cand` (4 bits, candidate code) and `cnt` (DBW bits).
- FSM states:
  - IDLE: `s2` == `sw_out`; `cnt` held at 0.
  - SETTLE: counting stable cycles of `cand`.
  - PENDING: `cand` is stable, differs from `sw_out`, and waits for `period_wrap`.
- Transitions:
  - Any state, `s2` != `cand`: load `cand` <= `s2`, `cnt` <= 0, go to SETTLE. In IDLE, a change back to `s2` == `sw_out` also enters SETTLE.
  - SETTLE, `s2` == `cand`, `cnt` < DB_CYCLES-1: `cnt` <= `cnt`+1.
  - SETTLE, `s2` == `cand`, `cnt` == DB_CYCLES-1, `cand` == `sw_out`: go to IDLE, no commit.
  - SETTLE, `s2` == `cand`, `cnt` == DB_CYCLES-1, `cand` != `sw_out`: go to PENDING.
  - PENDING, `period_wrap`=1, `s2` == `cand`: `sw_out` <= `cand`, `duty_changed` <= 1, go to IDLE.
  - PENDING, `period_wrap`=0: hold.
- Arithmetic:
  - `cnt` never exceeds DB_CYCLES-1, so it cannot wrap.
  - The compare uses full DBW width.
- `busy` = (state != IDLE), decoded from the state register only.
- `period_wrap` is ignored in IDLE and SETTLE.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - `sw_out`=0, `duty_changed`=0, `busy`=0.
  - `s1`=`s2`=0, `cand`=0, `cnt`=0, state IDLE.
- Release: first state update on the first rising edge with `rst_n`=1.
- Latency:
  - A `sw_raw` step appears on `s2` after 2 edges.
  - SETTLE is entered on the next edge.
  - PENDING is entered DB_CYCLES edges later if the input stays stable.
  - `sw_out` updates on the edge that samples `period_wrap`=1 in PENDING.
  - `duty_changed` is high for exactly the cycle following that edge.
- Simultaneous `period_wrap` and `s2` change in PENDING: the change wins; no commit; go to SETTLE with `cnt`=0.
- Bounce during SETTLE: restart counting from 0 with the new `cand`.
- Reset mid-operation: abort immediately; `sw_out` returns to 0 and any pending code is discarded.
- `sw_out` changes at most once per PWM period and only at wrap.

## Configuration
- Macro: `PWM_DUTY_IMMEDIATE_EN`.
- Undefined (default): behaviour as above; commit waits for `period_wrap`.
- Defined:
  - PENDING is unused.
  - A stable `cand` != `sw_out` commits on the SETTLE completion edge itself (`cnt` == DB_CYCLES-1 and `s2` == `cand`) and goes to IDLE.
  - `period_wrap` is ignored entirely.
  - `duty_changed` timing is otherwise unchanged.

## Test plan
All scenarios use DB_CYCLES=4 and DBW=3.
- Reset check: assert `rst_n`=0 mid-count with `sw_raw`=4'hF → `sw_out`=0, `busy`=0, `duty_changed`=0 asynchronously; after release with `sw_raw`=0, `busy` stays 0.
- Clean change: `sw_raw` 0→4'hA held; `period_wrap` pulsed 20 cycles later → `busy` rises 3 edges after the step; `sw_out`=4'hA on the wrap edge; one `duty_changed` pulse.
- Bounce: `sw_raw` toggles 4'h3/4'h5 every 2 cycles for 10 cycles, then settles at 4'h5 → no commit during bouncing; commit of 4'h5 on the first wrap after stability.
- Revert: `sw_out`=4'h2; `sw_raw` goes to 4'h7 for 2 cycles, then back to 4'h2 → IDLE reached with no `duty_changed` and `sw_out` stays 4'h2.
- Collision: in PENDING with `cand`=4'h6, `sw_raw` changes to 4'h9 so that `s2` changes in the same cycle as `period_wrap` → no commit; 4'h9 commits on a later wrap.
- Macro build with `PWM_DUTY_IMMEDIATE_EN` defined: `sw_raw` 0→4'hC with `period_wrap` tied 0 → `sw_out`=4'hC exactly DB_CYCLES+3 edges after the step.
